// File: rtl/pipe_mips_fwd.sv
// Five-stage MIPS-style pipeline over a unified instruction/data memory, with interlocks and a control FSM.
// Define PIPE_MIPS_FORWARD_EN to forward EX operands from EX/MEM and MEM/WB; otherwise ID stalls on hazards.
//
//   state   | meaning
//   S_IDLE  | after reset, memory preload allowed, waiting for start
//   S_RUN   | pipeline executing; preload and start ignored
//   S_HALTED| HLT or invalid opcode retired; preload allowed, start reruns
module pipe_mips_fwd #(
  parameter int DW        = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int CNT_W     = 32,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             load_we,
  input  logic [AW-1:0]    load_addr,
  input  logic [DW-1:0]    load_data,
  input  logic [4:0]       dbg_raddr,
  output logic [DW-1:0]    dbg_rdata,
  input  logic [AW-1:0]    dbg_maddr,
  output logic [DW-1:0]    dbg_mdata,
  output logic             halted,
  output logic [AW-1:0]    pc,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  function automatic logic op_rr(input logic [5:0] op);
    return op <= OP_MUL;
  endfunction

  function automatic logic op_imm(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_SLTI);
  endfunction

  function automatic logic op_wr(input logic [5:0] op);
    return op_rr(op) || op_imm(op) || (op == OP_LW);
  endfunction

  function automatic logic op_uses_rs(input logic [5:0] op);
    return op_wr(op) || (op == OP_SW) || (op == OP_BNEQZ) || (op == OP_BEQZ);
  endfunction

  function automatic logic op_uses_rt(input logic [5:0] op);
    return op_rr(op) || (op == OP_SW);
  endfunction

  // HLT and every unknown opcode both end the program
  function automatic logic op_stop(input logic [5:0] op);
    return !op_uses_rs(op);
  endfunction

  function automatic logic [4:0] op_dest(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return op_rr(op) ? rd : rt;
  endfunction

  function automatic logic src_match(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] d);
    return (op_uses_rs(op) && rs == d) || (op_uses_rt(op) && rt == d);
  endfunction

  state_t state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             stop_q, stop_d;
  logic             go;

  logic [DW-1:0] regs_q [32];
  logic [DW-1:0] mem_q [MEM_DEPTH];

  logic          ifid_v_q;
  logic [31:0]   ifid_ir_q;
  logic [AW-1:0] ifid_npc_q;

  logic          idex_v_q;
  logic [31:0]   idex_ir_q;
  logic [AW-1:0] idex_npc_q;
  logic [DW-1:0] idex_a_q, idex_b_q;

  logic          exmem_v_q, exmem_wr_q;
  logic [5:0]    exmem_op_q;
  logic [4:0]    exmem_rd_q;
  logic [DW-1:0] exmem_res_q, exmem_b_q;

  logic          memwb_v_q, memwb_wr_q;
  logic [5:0]    memwb_op_q;
  logic [4:0]    memwb_rd_q;
  logic [DW-1:0] memwb_res_q;

  logic [DW-1:0] if_word;
  logic [5:0]    id_op, ex_op;
  logic [4:0]    id_rs, id_rt, ex_dest;
  logic [DW-1:0] id_a, id_b, ex_a, ex_b, ex_imm, ex_res;
  logic [AW-1:0] ex_target, mem_addr;
  logic [DW-1:0] mem_val;
  logic          run, wb_we, wb_halt, mem_we, ex_taken, ex_hit, hazard, stall, fetch_en;

  assign run     = (state_q == S_RUN);
  assign pc_inc  = (pc_q == AW'(MEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
  assign if_word = mem_q[pc_q];

  assign id_op = ifid_ir_q[31:26];
  assign id_rs = ifid_ir_q[25:21];
  assign id_rt = ifid_ir_q[20:16];

  assign wb_we   = run && memwb_v_q && memwb_wr_q && (memwb_rd_q != 5'd0);
  assign wb_halt = run && memwb_v_q && op_stop(memwb_op_q);

  // Same-cycle WB write is visible to the ID read
  always_comb begin
    id_a = regs_q[id_rs];
    id_b = regs_q[id_rt];
    if (wb_we && memwb_rd_q == id_rs) id_a = memwb_res_q;
    if (wb_we && memwb_rd_q == id_rt) id_b = memwb_res_q;
  end

  assign ex_op   = idex_ir_q[31:26];
  assign ex_dest = op_dest(ex_op, idex_ir_q[20:16], idex_ir_q[15:11]);
  assign ex_imm  = {{(DW-16){idex_ir_q[15]}}, idex_ir_q[15:0]};
  assign ex_hit  = idex_v_q && op_wr(ex_op) && (ex_dest != 5'd0) &&
                   src_match(id_op, id_rs, id_rt, ex_dest);

`ifdef PIPE_MIPS_FORWARD_EN
  logic [4:0] ex_rs, ex_rt;
  assign ex_rs = idex_ir_q[25:21];
  assign ex_rt = idex_ir_q[20:16];

  // EX/MEM is younger than MEM/WB so it is checked first; loads are not ready in EX/MEM
  always_comb begin
    ex_a = idex_a_q;
    ex_b = idex_b_q;
    if (ex_rs != 5'd0 && exmem_v_q && exmem_wr_q && exmem_op_q != OP_LW && exmem_rd_q == ex_rs)
      ex_a = exmem_res_q;
    else if (ex_rs != 5'd0 && memwb_v_q && memwb_wr_q && memwb_rd_q == ex_rs)
      ex_a = memwb_res_q;
    if (ex_rt != 5'd0 && exmem_v_q && exmem_wr_q && exmem_op_q != OP_LW && exmem_rd_q == ex_rt)
      ex_b = exmem_res_q;
    else if (ex_rt != 5'd0 && memwb_v_q && memwb_wr_q && memwb_rd_q == ex_rt)
      ex_b = memwb_res_q;
  end

  assign hazard = ex_hit && (ex_op == OP_LW);
`else
  logic mem_hit;
  assign ex_a    = idex_a_q;
  assign ex_b    = idex_b_q;
  assign mem_hit = exmem_v_q && exmem_wr_q && (exmem_rd_q != 5'd0) &&
                   src_match(id_op, id_rs, id_rt, exmem_rd_q);
  assign hazard  = ex_hit || mem_hit;
`endif

  always_comb begin
    ex_res = '0;
    case (ex_op)
      OP_ADD:       ex_res = ex_a + ex_b;
      OP_SUB:       ex_res = ex_a - ex_b;
      OP_AND:       ex_res = ex_a & ex_b;
      OP_OR:        ex_res = ex_a | ex_b;
      OP_SLT:       ex_res = {{(DW-1){1'b0}}, $signed(ex_a) < $signed(ex_b)};
      OP_MUL:       ex_res = ex_a * ex_b;
      OP_LW, OP_SW: ex_res = ex_a + ex_imm;
      OP_ADDI:      ex_res = ex_a + ex_imm;
      OP_SUBI:      ex_res = ex_a - ex_imm;
      OP_SLTI:      ex_res = {{(DW-1){1'b0}}, $signed(ex_a) < $signed(ex_imm)};
      default:      ex_res = '0;
    endcase
  end

  assign ex_taken  = run && idex_v_q &&
                     ((ex_op == OP_BEQZ && ex_a == '0) || (ex_op == OP_BNEQZ && ex_a != '0));
  assign ex_target = idex_npc_q + ex_imm[AW-1:0];

  assign stall    = ifid_v_q && hazard;
  assign fetch_en = !stop_q && !(ifid_v_q && op_stop(id_op));

  assign mem_addr = exmem_res_q[AW-1:0];
  assign mem_val  = (exmem_op_q == OP_LW) ? mem_q[mem_addr] : exmem_res_q;
  assign mem_we   = run && exmem_v_q && (exmem_op_q == OP_SW);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stop_d    = stop_q;
    retired_d = retired_q;
    go        = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d   = S_RUN;
          pc_d      = '0;
          stop_d    = 1'b0;
          retired_d = '0;
          go        = 1'b1;
        end
      end
      S_RUN: begin
        if (memwb_v_q) retired_d = retired_q + 1'b1;
        if (wb_halt) begin
          state_d = S_HALTED;
        end else if (ex_taken) begin
          pc_d = ex_target;
        end else if (!stall) begin
          if (fetch_en) pc_d = pc_inc;
          if (ifid_v_q && op_stop(id_op)) stop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      retired_q   <= '0;
      stop_q      <= 1'b0;
      ifid_v_q    <= 1'b0;
      ifid_ir_q   <= '0;
      ifid_npc_q  <= '0;
      idex_v_q    <= 1'b0;
      idex_ir_q   <= '0;
      idex_npc_q  <= '0;
      idex_a_q    <= '0;
      idex_b_q    <= '0;
      exmem_v_q   <= 1'b0;
      exmem_wr_q  <= 1'b0;
      exmem_op_q  <= '0;
      exmem_rd_q  <= '0;
      exmem_res_q <= '0;
      exmem_b_q   <= '0;
      memwb_v_q   <= 1'b0;
      memwb_wr_q  <= 1'b0;
      memwb_op_q  <= '0;
      memwb_rd_q  <= '0;
      memwb_res_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      stop_q    <= stop_d;
      if (go || wb_halt) begin
        ifid_v_q  <= 1'b0;
        idex_v_q  <= 1'b0;
        exmem_v_q <= 1'b0;
        memwb_v_q <= 1'b0;
      end else if (run) begin
        memwb_v_q   <= exmem_v_q;
        memwb_wr_q  <= exmem_wr_q;
        memwb_op_q  <= exmem_op_q;
        memwb_rd_q  <= exmem_rd_q;
        memwb_res_q <= mem_val;
        exmem_v_q   <= idex_v_q;
        exmem_wr_q  <= op_wr(ex_op);
        exmem_op_q  <= ex_op;
        exmem_rd_q  <= ex_dest;
        exmem_res_q <= ex_res;
        exmem_b_q   <= ex_b;
        if (ex_taken) begin
          ifid_v_q <= 1'b0;
          idex_v_q <= 1'b0;
        end else if (stall) begin
          idex_v_q <= 1'b0;
        end else begin
          idex_v_q   <= ifid_v_q;
          idex_ir_q  <= ifid_ir_q;
          idex_npc_q <= ifid_npc_q;
          idex_a_q   <= id_a;
          idex_b_q   <= id_b;
          ifid_v_q   <= fetch_en;
          ifid_ir_q  <= if_word[31:0];
          ifid_npc_q <= pc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[memwb_rd_q] <= memwb_res_q;
    end
  end

  // Memory contents survive reset
  always_ff @(posedge clk) begin
    if (!run && load_we) mem_q[load_addr] <= load_data;
    else if (mem_we)     mem_q[mem_addr]  <= exmem_b_q;
  end

  assign dbg_rdata     = (dbg_raddr == 5'd0) ? '0 : regs_q[dbg_raddr];
  assign dbg_mdata     = mem_q[dbg_maddr];
  assign halted        = (state_q == S_HALTED);
  assign pc            = pc_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_pipe_mips_fwd.sv
// Self-checking bench for pipe_mips_fwd: directed programs plus random programs against an instruction-level model.
module tb_pipe_mips_fwd;

  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4, MUL = 6'd5;
  localparam logic [5:0] LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11, SLTI = 6'd12;
  localparam logic [5:0] BNEQZ = 6'd13, BEQZ = 6'd14, HLT = 6'h3F;

  logic        clk, rst_n, start, load_we, halted;
  logic [9:0]  load_addr, dbg_maddr, pc;
  logic [31:0] load_data, dbg_rdata, dbg_mdata, instr_retired;
  logic [4:0]  dbg_raddr;

  logic [31:0] mreg [32];
  logic [31:0] mmem [1024];
  logic [5:0]  ops [13];
  int n_chk = 0, n_pass = 0;

  pipe_mips_fwd dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .dbg_maddr(dbg_maddr), .dbg_mdata(dbg_mdata), .halted(halted), .pc(pc),
    .instr_retired(instr_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic load(input int addr, input logic [31:0] data);
    @(negedge clk);
    load_we = 1'b1; load_addr = 10'(addr); load_data = data;
    @(negedge clk);
    load_we = 1'b0;
    mmem[addr] = data;
  endtask

  task automatic reset_dut();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
  endtask

  function automatic logic [31:0] rd_reg(input int r);
    return mreg[r];
  endfunction

  task automatic get_reg(input int r, output logic [31:0] v);
    dbg_raddr = 5'(r); #1; v = dbg_rdata;
  endtask

  task automatic get_mem(input int a, output logic [31:0] v);
    dbg_maddr = 10'(a); #1; v = dbg_mdata;
  endtask

  // start pulse; cyc = rising edges after the start edge until halted is seen
  task automatic run(input int budget, input bit disturb, output int cyc);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!halted && cyc < budget) begin
      if (disturb && cyc == 10) begin
        start = 1'b1; load_we = 1'b1; load_addr = 10'd300; load_data = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1; cyc++;
      start = 1'b0; load_we = 1'b0;
    end
    chk("halted", halted, 1);
  endtask

  // Architectural reference: one instruction at a time, no pipeline
  task automatic model_run(output int ret);
    logic [31:0] ir, a, b, imm, p;
    logic [5:0]  op;
    p = 0; ret = 0;
    for (int n = 0; n < 5000; n++) begin
      ir = mmem[p]; op = ir[31:26];
      a = mreg[ir[25:21]]; b = mreg[ir[20:16]];
      imm = {{16{ir[15]}}, ir[15:0]};
      ret++;
      p = (p + 1) & 32'h3FF;
      case (op)
        ADD:   if (ir[15:11] != 0) mreg[ir[15:11]] = a + b;
        SUB:   if (ir[15:11] != 0) mreg[ir[15:11]] = a - b;
        AND_:  if (ir[15:11] != 0) mreg[ir[15:11]] = a & b;
        OR_:   if (ir[15:11] != 0) mreg[ir[15:11]] = a | b;
        SLT:   if (ir[15:11] != 0) mreg[ir[15:11]] = ($signed(a) < $signed(b)) ? 1 : 0;
        MUL:   if (ir[15:11] != 0) mreg[ir[15:11]] = a * b;
        LW:    if (ir[20:16] != 0) mreg[ir[20:16]] = mmem[(a + imm) & 32'h3FF];
        SW:    mmem[(a + imm) & 32'h3FF] = b;
        ADDI:  if (ir[20:16] != 0) mreg[ir[20:16]] = a + imm;
        SUBI:  if (ir[20:16] != 0) mreg[ir[20:16]] = a - imm;
        SLTI:  if (ir[20:16] != 0) mreg[ir[20:16]] = ($signed(a) < $signed(imm)) ? 1 : 0;
        BNEQZ: if (a != 0) p = (p + imm) & 32'h3FF;
        BEQZ:  if (a == 0) p = (p + imm) & 32'h3FF;
        default: return;
      endcase
    end
  endtask

  task automatic load_factorial();
    load(0, enc_i(LW, 3, 0, 200));
    load(1, enc_i(ADDI, 2, 0, 1));
    load(2, enc_r(MUL, 2, 2, 3));
    load(3, enc_i(SUBI, 3, 3, 1));
    load(4, enc_i(BNEQZ, 0, 3, -3));
    load(5, enc_i(SW, 2, 0, 198));
    load(6, {HLT, 26'd0});
    load(7, enc_i(ADDI, 7, 0, 1));
    load(8, enc_i(SW, 2, 0, 199));
    load(198, 32'h0);
    load(199, 32'h55);
    load(200, 32'd7);
  endtask

  initial begin
    logic [31:0] v;
    int cyc, ret, n, k, rd, rs, rt, imm, mx;
    logic [5:0] op;
    ops = '{ADD, SUB, AND_, OR_, SLT, MUL, LW, SW, ADDI, SUBI, SLTI, BNEQZ, BEQZ};
    rst_n = 1'b0; start = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
    dbg_raddr = '0; dbg_maddr = '0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    for (int i = 0; i < 1024; i++) mmem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retired", instr_retired, 0);
    get_reg(5, v); chk("rst_r5", v, 0);
    @(negedge clk); rst_n = 1'b1;

    // dependent ALU chain
    load(0, enc_i(ADDI, 1, 0, 5));
    load(1, enc_r(ADD, 2, 1, 1));
    load(2, enc_r(ADD, 3, 2, 1));
    load(3, {HLT, 26'd0});
    run(200, 1'b0, cyc);
`ifdef PIPE_MIPS_FORWARD_EN
    chk("chain_cycles", cyc, 8);
`else
    chk("chain_cycles", cyc, 12);
`endif
    get_reg(3, v); chk("chain_r3", v, 15);
    chk("chain_retired", instr_retired, 4);

    // load-use
    reset_dut();
    load(200, 32'd7);
    load(0, enc_i(LW, 1, 0, 200));
    load(1, enc_r(ADD, 2, 1, 1));
    load(2, {HLT, 26'd0});
    run(200, 1'b0, cyc);
`ifdef PIPE_MIPS_FORWARD_EN
    chk("ldu_cycles", cyc, 8);
`else
    chk("ldu_cycles", cyc, 9);
`endif
    get_reg(2, v); chk("ldu_r2", v, 14);

    // taken branch flushes two younger instructions
    reset_dut();
    load(0, enc_i(BEQZ, 0, 0, 2));
    load(1, enc_i(ADDI, 4, 0, 9));
    load(2, enc_i(ADDI, 5, 0, 9));
    load(3, enc_i(ADDI, 6, 0, 3));
    load(4, {HLT, 26'd0});
    run(200, 1'b0, cyc);
    chk("br_cycles", cyc, 9);
    get_reg(4, v); chk("br_r4", v, 0);
    get_reg(5, v); chk("br_r5", v, 0);
    get_reg(6, v); chk("br_r6", v, 3);
    chk("br_retired", instr_retired, 3);

    // factorial, with start and load_we pulsed mid-run
    reset_dut();
    load_factorial();
    load(300, 32'h0000_1111);
    run(2000, 1'b1, cyc);
    get_mem(198, v); chk("fact_m198", v, 5040);
    get_mem(199, v); chk("fact_m199", v, 32'h55);
    get_reg(7, v); chk("fact_r7", v, 0);
    chk("fact_retired", instr_retired, 25);
    get_mem(300, v); chk("run_load_ignored", v, 32'h0000_1111);
    load(300, 32'h1234_5678);
    get_mem(300, v); chk("halted_load", v, 32'h1234_5678);

    // reset in the middle of a run
    reset_dut();
    load(198, 32'h0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_retired", instr_retired, 0);
    get_reg(2, v); chk("mid_rst_r2", v, 0);
    get_reg(3, v); chk("mid_rst_r3", v, 0);
    get_mem(200, v); chk("mid_rst_m200", v, 7);
    get_mem(0, v); chk("mid_rst_m0", v, mmem[0]);
    @(negedge clk); rst_n = 1'b1;
    run(2000, 1'b0, cyc);
    get_mem(198, v); chk("rerun_m198", v, 5040);
    chk("rerun_retired", instr_retired, 25);

    // random programs; odd iterations keep registers across start
    for (int it = 0; it < 8; it++) begin
      if (it % 2 == 0) reset_dut();
      for (int a = 512; a < 544; a++) load(a, $urandom);
      n = $urandom_range(10, 24);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 12); op = ops[k];
        rd = $urandom_range(0, 7); rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
        imm = $urandom_range(0, 65535);
        if (op == LW || op == SW) begin rs = 0; imm = 512 + $urandom_range(0, 31); end
        if (op == BEQZ || op == BNEQZ) begin
          mx = n - (i + 1);
          imm = $urandom_range(0, (mx < 3) ? mx : 3);
        end
        load(i, (op <= MUL) ? enc_r(op, rd, rs, rt) : enc_i(op, rt, rs, imm));
      end
      load(n, {HLT, 26'd0});
      model_run(ret);
      run(1000, 1'b0, cyc);
      chk($sformatf("rnd%0d_retired", it), instr_retired, ret);
      for (int r = 1; r < 8; r++) begin
        get_reg(r, v); chk($sformatf("rnd%0d_r%0d", it, r), v, rd_reg(r));
      end
      for (int a = 512; a < 544; a++) begin
        get_mem(a, v); chk($sformatf("rnd%0d_m%0d", it, a), v, mmem[a]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
